// File: rtl/npc_mem_arb_if.sv
// Shared-memory arbiter bundle: IFU and LSU request/response ports
// plus the single downstream memory port.
interface npc_mem_arb_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
);

  logic                    ifu_req_valid_i;
  logic                    ifu_req_ready_o;
  logic [ADDR_WIDTH-1:0]   ifu_addr_i;
  logic                    ifu_rsp_valid_o;
  logic [DATA_WIDTH-1:0]   ifu_rsp_data_o;

  logic                    lsu_req_valid_i;
  logic                    lsu_req_ready_o;
  logic [ADDR_WIDTH-1:0]   lsu_addr_i;
  logic                    lsu_wen_i;
  logic [DATA_WIDTH-1:0]   lsu_wdata_i;
  logic [DATA_WIDTH/8-1:0] lsu_wstrb_i;
  logic                    lsu_rsp_valid_o;
  logic [DATA_WIDTH-1:0]   lsu_rsp_data_o;

  logic                    mem_req_valid_o;
  logic                    mem_req_ready_i;
  logic [ADDR_WIDTH-1:0]   mem_addr_o;
  logic                    mem_wen_o;
  logic [DATA_WIDTH-1:0]   mem_wdata_o;
  logic [DATA_WIDTH/8-1:0] mem_wstrb_o;
  logic                    mem_rsp_valid_i;
  logic [DATA_WIDTH-1:0]   mem_rsp_data_i;

  logic                    busy_o;

  modport slave (
    input  ifu_req_valid_i,
    output ifu_req_ready_o,
    input  ifu_addr_i,
    output ifu_rsp_valid_o,
    output ifu_rsp_data_o,
    input  lsu_req_valid_i,
    output lsu_req_ready_o,
    input  lsu_addr_i,
    input  lsu_wen_i,
    input  lsu_wdata_i,
    input  lsu_wstrb_i,
    output lsu_rsp_valid_o,
    output lsu_rsp_data_o,
    output mem_req_valid_o,
    input  mem_req_ready_i,
    output mem_addr_o,
    output mem_wen_o,
    output mem_wdata_o,
    output mem_wstrb_o,
    input  mem_rsp_valid_i,
    input  mem_rsp_data_i,
    output busy_o
  );

  modport master (
    output ifu_req_valid_i,
    input  ifu_req_ready_o,
    output ifu_addr_i,
    input  ifu_rsp_valid_o,
    input  ifu_rsp_data_o,
    output lsu_req_valid_i,
    input  lsu_req_ready_o,
    output lsu_addr_i,
    output lsu_wen_i,
    output lsu_wdata_i,
    output lsu_wstrb_i,
    input  lsu_rsp_valid_o,
    input  lsu_rsp_data_o,
    input  mem_req_valid_o,
    output mem_req_ready_i,
    input  mem_addr_o,
    input  mem_wen_o,
    input  mem_wdata_o,
    input  mem_wstrb_o,
    output mem_rsp_valid_i,
    output mem_rsp_data_i,
    input  busy_o
  );

endinterface

// File: rtl/npc_mem_arb.sv
// Round-robin arbiter sharing one memory port between IFU and LSU,
// one transaction outstanding: IDLE -> ISSUE -> WAIT -> RESP.
module npc_mem_arb #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
) (
  input logic         clk,
  input logic         rst_n,
  npc_mem_arb_if.slave bus
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  typedef enum logic {
    SRC_IFU,
    SRC_LSU
  } src_e;

  state_e state_q;
  state_e state_d;
  src_e   last_q;
  src_e   owner_q;
  src_e   winner;

  logic                  any_req;
  logic                  grant;
  logic                  rsp_take;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  wen_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] wstrb_q;
  logic [DATA_WIDTH-1:0] ifu_data_q;
  logic [DATA_WIDTH-1:0] lsu_data_q;

  // On a conflict the requester that did not win last time goes first.
  always_comb begin
    any_req = bus.ifu_req_valid_i | bus.lsu_req_valid_i;
    winner  = SRC_IFU;
    unique case (1'b1)
      bus.ifu_req_valid_i && bus.lsu_req_valid_i:
        winner = (last_q == SRC_IFU) ? SRC_LSU : SRC_IFU;
      bus.lsu_req_valid_i && !bus.ifu_req_valid_i:
        winner = SRC_LSU;
      default:
        winner = SRC_IFU;
    endcase
  end

  // rst_n gates the grant so ready stays low while reset is held.
  assign grant    = rst_n && (state_q == IDLE) && any_req;
  assign rsp_take = (state_q == WAIT) && bus.mem_rsp_valid_i;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req) state_d = ISSUE;
      ISSUE:   if (bus.mem_req_ready_i) state_d = WAIT;
      WAIT:    if (bus.mem_rsp_valid_i) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= SRC_IFU;
      owner_q <= SRC_IFU;
    end else begin
      state_q <= state_d;
      if (grant) begin
        last_q  <= winner;
        owner_q <= winner;
      end
    end
  end

  // IFU requests are reads: the write fields are cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (grant) begin
      if (winner == SRC_LSU) begin
        addr_q  <= bus.lsu_addr_i;
        wen_q   <= bus.lsu_wen_i;
        wdata_q <= bus.lsu_wdata_i;
        wstrb_q <= bus.lsu_wstrb_i;
      end else begin
        addr_q  <= bus.ifu_addr_i;
        wen_q   <= 1'b0;
        wdata_q <= '0;
        wstrb_q <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifu_data_q <= '0;
      lsu_data_q <= '0;
    end else if (rsp_take) begin
      if (owner_q == SRC_LSU) begin
        lsu_data_q <= bus.mem_rsp_data_i;
      end else begin
        ifu_data_q <= bus.mem_rsp_data_i;
      end
    end
  end

  assign bus.ifu_req_ready_o = grant && (winner == SRC_IFU);
  assign bus.lsu_req_ready_o = grant && (winner == SRC_LSU);

  assign bus.mem_req_valid_o = (state_q == ISSUE);
  assign bus.mem_addr_o      = addr_q;
  assign bus.mem_wen_o       = wen_q;
  assign bus.mem_wdata_o     = wdata_q;
  assign bus.mem_wstrb_o     = wstrb_q;

  assign bus.ifu_rsp_valid_o =
    (state_q == RESP) && (owner_q == SRC_IFU);
  assign bus.lsu_rsp_valid_o =
    (state_q == RESP) && (owner_q == SRC_LSU);
  assign bus.ifu_rsp_data_o  = ifu_data_q;
  assign bus.lsu_rsp_data_o  = lsu_data_q;

  assign bus.busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_npc_mem_arb.sv
// Bench for npc_mem_arb: directed scenarios plus random traffic
// checked against a transaction-level model of the arbiter.
module tb_npc_mem_arb;

  localparam int AW = 32;
  localparam int DW = 64;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  npc_mem_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  npc_mem_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  // Model: one transaction record, 0 = IFU, 1 = LSU.
  bit          m_act, m_iss, m_rsp, m_own, m_last;
  logic [AW-1:0] m_addr;
  logic          m_wen;
  logic [DW-1:0] m_wdata;
  logic [SW-1:0] m_wstrb;
  logic [DW-1:0] m_ifu_data, m_lsu_data;
  bit          g_ifu, g_lsu;
  int          grants[$];
  int          n_ifu_rdy, n_lsu_rdy, n_ifu_rsp, n_lsu_rsp;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit m_win();
    return bus.lsu_req_valid_i &&
           (!bus.ifu_req_valid_i || m_last == 1'b0);
  endfunction

  task automatic m_reset();
    m_act = 0; m_iss = 0; m_rsp = 0; m_own = 0; m_last = 0;
    m_ifu_data = '0; m_lsu_data = '0;
  endtask

  task automatic check_zero();
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_ifu_ready", bus.ifu_req_ready_o, 0);
    chk("rst_lsu_ready", bus.lsu_req_ready_o, 0);
    chk("rst_mem_valid", bus.mem_req_valid_o, 0);
    chk("rst_mem_addr", bus.mem_addr_o, 0);
    chk("rst_mem_wen", bus.mem_wen_o, 0);
    chk("rst_mem_wdata", bus.mem_wdata_o, 0);
    chk("rst_mem_wstrb", bus.mem_wstrb_o, 0);
    chk("rst_ifu_rsp", bus.ifu_rsp_valid_o, 0);
    chk("rst_lsu_rsp", bus.lsu_rsp_valid_o, 0);
    chk("rst_ifu_data", bus.ifu_rsp_data_o, 0);
    chk("rst_lsu_data", bus.lsu_rsp_data_o, 0);
  endtask

  task automatic settle();
    bit req, w;
    #1;
    req = bus.ifu_req_valid_i || bus.lsu_req_valid_i;
    w   = m_win();
    chk("busy", bus.busy_o, m_act);
    chk("ifu_ready", bus.ifu_req_ready_o, !m_act && req && !w);
    chk("lsu_ready", bus.lsu_req_ready_o, !m_act && req && w);
    chk("mem_valid", bus.mem_req_valid_o, m_act && !m_iss);
    if (m_act && !m_iss) begin
      chk("mem_addr", bus.mem_addr_o, m_addr);
      chk("mem_wen", bus.mem_wen_o, m_wen);
      chk("mem_wdata", bus.mem_wdata_o, m_wdata);
      chk("mem_wstrb", bus.mem_wstrb_o, m_wstrb);
    end
    chk("ifu_rsp", bus.ifu_rsp_valid_o, m_act && m_rsp && !m_own);
    chk("lsu_rsp", bus.lsu_rsp_valid_o, m_act && m_rsp && m_own);
    chk("ifu_data", bus.ifu_rsp_data_o, m_ifu_data);
    chk("lsu_data", bus.lsu_rsp_data_o, m_lsu_data);
    n_ifu_rdy += int'(bus.ifu_req_ready_o);
    n_lsu_rdy += int'(bus.lsu_req_ready_o);
    n_ifu_rsp += int'(bus.ifu_rsp_valid_o);
    n_lsu_rsp += int'(bus.lsu_rsp_valid_o);
  endtask

  task automatic edge_step();
    bit w;
    @(posedge clk);
    g_ifu = 0;
    g_lsu = 0;
    if (!m_act) begin
      if (bus.ifu_req_valid_i || bus.lsu_req_valid_i) begin
        w = m_win();
        m_act = 1; m_iss = 0; m_rsp = 0;
        m_own = w; m_last = w;
        grants.push_back(int'(w));
        if (w) begin
          g_lsu = 1;
          m_addr = bus.lsu_addr_i; m_wen = bus.lsu_wen_i;
          m_wdata = bus.lsu_wdata_i; m_wstrb = bus.lsu_wstrb_i;
        end else begin
          g_ifu = 1;
          m_addr = bus.ifu_addr_i; m_wen = 0;
          m_wdata = '0; m_wstrb = '0;
        end
      end
    end else if (m_rsp) begin
      m_act = 0;
    end else if (!m_iss) begin
      if (bus.mem_req_ready_i) m_iss = 1;
    end else if (bus.mem_rsp_valid_i) begin
      m_rsp = 1;
      if (m_own) m_lsu_data = bus.mem_rsp_data_i;
      else m_ifu_data = bus.mem_rsp_data_i;
    end
    #1;
  endtask

  task automatic cycle();
    settle();
    edge_step();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check_zero();
    m_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic idle_inputs();
    bus.ifu_req_valid_i = 0; bus.ifu_addr_i = '0;
    bus.lsu_req_valid_i = 0; bus.lsu_addr_i = '0;
    bus.lsu_wen_i = 0; bus.lsu_wdata_i = '0; bus.lsu_wstrb_i = '0;
    bus.mem_req_ready_i = 0; bus.mem_rsp_valid_i = 0;
    bus.mem_rsp_data_i = '0;
  endtask

  initial begin
    idle_inputs();
    m_reset();
    // Requests held during reset must not see ready.
    bus.ifu_req_valid_i = 1;
    bus.lsu_req_valid_i = 1;
    #2;
    check_zero();
    @(posedge clk);
    #1;
    idle_inputs();
    rst_n = 1'b1;

    // Single IFU read.
    bus.ifu_req_valid_i = 1;
    bus.ifu_addr_i = 32'h8000_0000;
    settle();
    chk("t1_ready", bus.ifu_req_ready_o, 1);
    edge_step();
    bus.ifu_req_valid_i = 0;
    bus.mem_req_ready_i = 1;
    settle();
    chk("t1_mem_valid", bus.mem_req_valid_o, 1);
    chk("t1_mem_addr", bus.mem_addr_o, 64'h8000_0000);
    chk("t1_mem_wen", bus.mem_wen_o, 0);
    edge_step();
    bus.mem_req_ready_i = 0;
    bus.mem_rsp_valid_i = 1;
    bus.mem_rsp_data_i = 64'h0000_0013_0000_0297;
    cycle();
    bus.mem_rsp_valid_i = 0;
    bus.mem_rsp_data_i = '0;
    settle();
    chk("t1_ifu_rsp", bus.ifu_rsp_valid_o, 1);
    chk("t1_ifu_data", bus.ifu_rsp_data_o, 64'h0000_0013_0000_0297);
    chk("t1_lsu_rsp", bus.lsu_rsp_valid_o, 0);
    edge_step();
    cycle();

    // Continuous contention after reset.
    apply_reset();
    grants.delete();
    n_ifu_rdy = 0; n_lsu_rdy = 0;
    bus.ifu_req_valid_i = 1; bus.ifu_addr_i = 32'h8000_0000;
    bus.lsu_req_valid_i = 1; bus.lsu_addr_i = 32'h8000_1000;
    bus.mem_req_ready_i = 1; bus.mem_rsp_valid_i = 1;
    bus.mem_rsp_data_i = 64'hA5A5_0000_1234_5678;
    for (int i = 0; i < 16; i++) cycle();
    chk("rr_count", grants.size(), 4);
    if (grants.size() >= 4) begin
      chk("rr_g0", grants[0], 1);
      chk("rr_g1", grants[1], 0);
      chk("rr_g2", grants[2], 1);
      chk("rr_g3", grants[3], 0);
    end
    chk("rr_ifu_ready_cycles", n_ifu_rdy, 2);
    chk("rr_lsu_ready_cycles", n_lsu_rdy, 2);
    idle_inputs();
    cycle();

    // LSU write with a stalled memory; spurious rsp in ISSUE.
    n_lsu_rsp = 0;
    bus.lsu_req_valid_i = 1; bus.lsu_wen_i = 1;
    bus.lsu_addr_i = 32'h8000_0100;
    bus.lsu_wdata_i = 64'h1122_3344_5566_7788;
    bus.lsu_wstrb_i = 8'h0F;
    cycle();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      bus.mem_rsp_valid_i = 1;
      bus.mem_rsp_data_i = 64'hDEAD_BEEF_0000_0000 + 64'(i);
      settle();
      chk("wr_mem_addr", bus.mem_addr_o, 64'h8000_0100);
      chk("wr_mem_wdata", bus.mem_wdata_o, 64'h1122_3344_5566_7788);
      chk("wr_mem_wstrb", bus.mem_wstrb_o, 8'h0F);
      chk("wr_mem_wen", bus.mem_wen_o, 1);
      edge_step();
    end
    bus.mem_rsp_valid_i = 0;
    bus.mem_req_ready_i = 1;
    cycle();
    bus.mem_req_ready_i = 0;
    bus.mem_rsp_valid_i = 1;
    bus.mem_rsp_data_i = 64'h0000_0000_0000_0ACC;
    cycle();
    bus.mem_rsp_valid_i = 0;
    for (int i = 0; i < 4; i++) cycle();
    chk("wr_ack_pulses", n_lsu_rsp, 1);
    chk("wr_ack_data", bus.lsu_rsp_data_o, 64'h0ACC);

    // IFU arrives while the LSU waits; reset in WAIT.
    bus.lsu_req_valid_i = 1; bus.lsu_wen_i = 0;
    bus.lsu_addr_i = 32'h8000_2000;
    cycle();
    bus.lsu_req_valid_i = 0;
    bus.mem_req_ready_i = 1;
    cycle();
    bus.mem_req_ready_i = 0;
    bus.ifu_req_valid_i = 1; bus.ifu_addr_i = 32'h8000_0040;
    n_ifu_rdy = 0;
    cycle();
    cycle();
    bus.mem_rsp_valid_i = 1;
    bus.mem_rsp_data_i = 64'h0BAD_F00D_0000_0001;
    cycle();
    bus.mem_rsp_valid_i = 0;
    cycle();
    chk("wait_ifu_ready_blocked", n_ifu_rdy, 0);
    settle();
    chk("ifu_granted_after", bus.ifu_req_ready_o, 1);
    edge_step();
    bus.ifu_req_valid_i = 0;
    bus.mem_req_ready_i = 1;
    cycle();
    bus.mem_req_ready_i = 0;
    apply_reset();
    n_ifu_rsp = 0; n_lsu_rsp = 0;
    bus.mem_rsp_valid_i = 1;
    for (int i = 0; i < 4; i++) cycle();
    bus.mem_rsp_valid_i = 0;
    chk("post_rst_ifu_pulse", n_ifu_rsp, 0);
    chk("post_rst_lsu_pulse", n_lsu_rsp, 0);

    // Random traffic.
    idle_inputs();
    for (int i = 0; i < 4000; i++) begin
      if (g_ifu) bus.ifu_req_valid_i = 0;
      if (g_lsu) bus.lsu_req_valid_i = 0;
      if (!bus.ifu_req_valid_i && $urandom_range(0, 2) == 0) begin
        bus.ifu_req_valid_i = 1;
        bus.ifu_addr_i = $urandom;
      end
      if (!bus.lsu_req_valid_i && $urandom_range(0, 2) == 0) begin
        bus.lsu_req_valid_i = 1;
        bus.lsu_addr_i = $urandom;
        bus.lsu_wen_i = 1'($urandom_range(0, 1));
        bus.lsu_wdata_i = {$urandom, $urandom};
        bus.lsu_wstrb_i = 8'($urandom);
      end
      bus.mem_req_ready_i = 1'($urandom_range(0, 1));
      bus.mem_rsp_valid_i = ($urandom_range(0, 2) == 0);
      bus.mem_rsp_data_i = {$urandom, $urandom};
      if ($urandom_range(0, 199) == 0) begin
        apply_reset();
        g_ifu = 0;
        g_lsu = 0;
      end else begin
        cycle();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
